sta_tile_scheduler: RTL and testbench

Sequences the 4x4 systolic tensor array datapath (STA, output coordinator, requant, maxpool) across every output tile of one layer. On start it walks tile positions in steps of SA_N, row-major with column innermost. For each tile it pulses load_bias, streams k_steps operand vectors, asserts done, waits for the pipeline to go idle, then clears the STA with reset_sta. It sits between the layer controller and the STA datapath and drives its pos_row/pos_col/done/load_bias/reset_sta inputs plus the operand-buffer read strobe.

---
 rtl/sta_sched_pkg.sv | 21 ++
 rtl/tile_pos_counter.sv | 70 +++++++
 rtl/sta_tile_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_sta_tile_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sta_sched_pkg.sv
// Shared definitions for the STA tile scheduler.
//   SA_N          : systolic array edge, which is also the tile step
//   DRAIN_MIN     : minimum number of unstalled DRAIN cycles before CLEAR
//   sched_state_e : per-tile sequencing states
package sta_sched_pkg;

  localparam int SA_N      = 4;
  localparam int DRAIN_MIN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_FEED,
    S_FLUSH,
    S_DONE,
    S_DRAIN,
    S_CLEAR,
    S_FIN
  } sched_state_e;

endpackage

// File: rtl/tile_pos_counter.sv
// Tile base-position counter for the STA tile scheduler.
// Walks row-major, column innermost, in steps of STEP.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : zero both coordinates (layer start)
//   advance_i    : step to the next tile
//   out_dim_i    : output map edge
//   pos_row_o    : current tile base row (registered)
//   pos_col_o    : current tile base col (registered)
//   last_o       : current tile is the final one of the layer
module tile_pos_counter
  import sta_sched_pkg::*;
#(
  parameter int N_BITS = 6,
  parameter int STEP   = SA_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [N_BITS-1:0] out_dim_i,
  output logic [N_BITS-1:0] pos_row_o,
  output logic [N_BITS-1:0] pos_col_o,
  output logic              last_o
);

  localparam logic [N_BITS:0] STEP_W = (N_BITS+1)'(STEP);

  logic [N_BITS-1:0] row_q, row_d, col_q, col_d;
  logic [N_BITS:0]   col_inc, row_inc, dim_ext;
  logic              col_wrap;

  // One extra bit so a step past the top of the coordinate range still
  // compares as beyond the map edge.
  assign dim_ext  = {1'b0, out_dim_i};
  assign col_inc  = {1'b0, col_q} + STEP_W;
  assign row_inc  = {1'b0, row_q} + STEP_W;
  assign col_wrap = col_inc >= dim_ext;
  assign last_o   = col_wrap && (row_inc >= dim_ext);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_inc[N_BITS-1:0];
      end else begin
        col_d = col_inc[N_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign pos_row_o = row_q;
  assign pos_col_o = col_q;

endmodule

// File: rtl/sta_tile_scheduler.sv
// Sequences the 4x4 systolic tensor array across every output tile of a
// layer: per tile BIAS -> FEED(k_steps) -> FLUSH -> DONE -> DRAIN -> CLEAR.
// Optional macro STA_SCHED_PERF_EN adds busy/stall cycle counters.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start                 : layer start, accepted only in IDLE
//   out_dim, k_steps      : layer geometry, latched on accepted start
//   stall                 : global stall, freezes everything
//   sta_idle              : datapath idle, gates DRAIN exit
//   busy, layer_done      : layer status
//   pos_row, pos_col      : tile base coordinates
//   load_bias, feed_en, feed_k, done, reset_sta : datapath strobes
//   perf_busy_cycles, perf_stall_cycles : (STA_SCHED_PERF_EN only)
module sta_tile_scheduler #(
  parameter int MAX_N        = 64,
  parameter int N_BITS       = $clog2(MAX_N),
  parameter int SA_N         = sta_sched_pkg::SA_N,
  parameter int MAX_K        = 1024,
  parameter int K_BITS       = $clog2(MAX_K+1),
  parameter int FLUSH_CYCLES = 3*SA_N-2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [N_BITS-1:0] out_dim,
  input  logic [K_BITS-1:0] k_steps,
  input  logic              stall,
  input  logic              sta_idle,
  output logic              busy,
  output logic              layer_done,
  output logic [N_BITS-1:0] pos_row,
  output logic [N_BITS-1:0] pos_col,
  output logic              load_bias,
  output logic              feed_en,
  output logic [K_BITS-1:0] feed_k,
  output logic              done,
  output logic              reset_sta
`ifdef STA_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  import sta_sched_pkg::*;

  localparam logic [K_BITS-1:0] FLUSH_LAST = K_BITS'(FLUSH_CYCLES-1);
  localparam logic [K_BITS-1:0] DRAIN_LAST = K_BITS'(DRAIN_MIN-1);

  sched_state_e      state_q, state_d;
  logic [K_BITS-1:0] cnt_q, cnt_d, cnt_inc;
  logic [K_BITS-1:0] k_q;
  logic [N_BITS-1:0] dim_q;
  logic              accept, advance, last;

  logic              busy_d, layer_done_d, load_bias_d, feed_en_d, done_d, reset_sta_d;
  logic [K_BITS-1:0] feed_k_d;

  assign accept  = (state_q == S_IDLE) && start && !stall;
  assign advance = (state_q == S_CLEAR) && !stall;
  assign cnt_inc = cnt_q + K_BITS'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dim_q <= '0;
      k_q   <= '0;
    end else if (accept) begin
      dim_q <= out_dim;
      k_q   <= k_steps;
    end
  end

  tile_pos_counter #(
    .N_BITS (N_BITS),
    .STEP   (SA_N)
  ) u_pos (
    .clk       (clk),
    .rst_n     (reset_n),
    .clear_i   (accept),
    .advance_i (advance),
    .out_dim_i (dim_q),
    .pos_row_o (pos_row),
    .pos_col_o (pos_col),
    .last_o    (last)
  );

  // State, shared phase counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      load_bias  <= 1'b0;
      feed_en    <= 1'b0;
      feed_k     <= '0;
      done       <= 1'b0;
      reset_sta  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      layer_done <= layer_done_d;
      load_bias  <= load_bias_d;
      feed_en    <= feed_en_d;
      feed_k     <= feed_k_d;
      done       <= done_d;
      reset_sta  <= reset_sta_d;
    end
  end

  // cnt_q is the feed index in FEED, the cycle count in FLUSH and the
  // unstalled-cycle count in DRAIN (saturating at DRAIN_LAST).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) state_d = (out_dim == '0) ? S_FIN : S_BIAS;
        end
        S_BIAS: begin
          cnt_d   = '0;
          state_d = (k_q == '0) ? S_FLUSH : S_FEED;
        end
        S_FEED: begin
          if (cnt_inc == k_q) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DONE: begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
        S_DRAIN: begin
          if (cnt_q >= DRAIN_LAST) begin
            if (sta_idle) begin
              state_d = S_CLEAR;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_CLEAR: state_d = last ? S_FIN : S_BIAS;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are a function of the next state so they land in registers.
  always_comb begin
    busy_d       = (state_d != S_IDLE) && (state_d != S_FIN);
    layer_done_d = (state_d == S_FIN);
    load_bias_d  = (state_d == S_BIAS);
    feed_en_d    = (state_d == S_FEED);
    feed_k_d     = (state_d == S_FEED) ? cnt_d : '0;
    done_d       = (state_d == S_DONE);
    reset_sta_d  = (state_d == S_CLEAR);
  end

`ifdef STA_SCHED_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (accept) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy && !(&perf_busy_q))           perf_busy_q  <= perf_busy_q + 32'd1;
      if (busy && stall && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_sta_tile_scheduler.sv
`timescale 1ns/1ps
module tb_sta_tile_scheduler;

  localparam int NB = 6;
  localparam int KB = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          sta_idle = 1'b1;
  logic [NB-1:0] out_dim = '0;
  logic [KB-1:0] k_steps = '0;
  logic          busy, layer_done, load_bias, feed_en, done, reset_sta;
  logic [NB-1:0] pos_row, pos_col;
  logic [KB-1:0] feed_k;
`ifdef STA_SCHED_PERF_EN
  logic [31:0]   perf_busy_cycles, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  sta_tile_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .out_dim    (out_dim),
    .k_steps    (k_steps),
    .stall      (stall),
    .sta_idle   (sta_idle),
    .busy       (busy),
    .layer_done (layer_done),
    .pos_row    (pos_row),
    .pos_col    (pos_col),
    .load_bias  (load_bias),
    .feed_en    (feed_en),
    .feed_k     (feed_k),
    .done       (done),
    .reset_sta  (reset_sta)
`ifdef STA_SCHED_PERF_EN
    ,
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Reference model: the whole layer is expanded into a list of expected
  // per-cycle output words; a DRAIN word is held until its exit rule is met.
  typedef struct {
    bit busy, lb, fe, dn, rs, ld;
    int fk, row, col;
    bit pos_chk, drain;
  } word_t;

  word_t q[$];
  word_t cur;
  int    dseen;
  int    n_vec = 0, n_err = 0, cyc_g = 0;
  int    n_done, n_rs, n_feed, n_ld;

  function automatic word_t blank(bit b, int r, int c);
    word_t w;
    w.busy = b; w.lb = 0; w.fe = 0; w.dn = 0; w.rs = 0; w.ld = 0;
    w.fk = 0; w.row = r; w.col = c; w.pos_chk = b; w.drain = 0;
    return w;
  endfunction

  function automatic void build(int od, int k);
    word_t w;
    for (int r = 0; r < od; r += 4)
      for (int c = 0; c < od; c += 4) begin
        w = blank(1, r, c); w.lb = 1; q.push_back(w);
        for (int i = 0; i < k; i++) begin
          w = blank(1, r, c); w.fe = 1; w.fk = i; q.push_back(w);
        end
        for (int i = 0; i < 10; i++) q.push_back(blank(1, r, c));
        w = blank(1, r, c); w.dn = 1; q.push_back(w);
        w = blank(1, r, c); w.drain = 1; q.push_back(w);
        w = blank(1, r, c); w.rs = 1; q.push_back(w);
      end
    w = blank(0, 0, 0); w.ld = 1; q.push_back(w);
  endfunction

  function automatic void pop();
    if (q.size() > 0) cur = q.pop_front();
    else cur = blank(0, 0, 0);
    dseen = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare, return at negedge.
  task automatic tick();
    logic [28:0] act, exp, mask;
    @(posedge clk);
    #1;
    cyc_g++;
    if (!reset_n) begin
      q.delete();
      cur = blank(0, 0, 0);
      cur.pos_chk = 1;
    end else if (!stall) begin
      if (q.size() == 0 && !cur.busy && !cur.ld && start) begin
        build(int'(out_dim), int'(k_steps));
        pop();
      end else if (cur.drain) begin
        dseen++;
        if (dseen >= 2 && sta_idle) pop();
      end else begin
        pop();
      end
    end
    mask = cur.pos_chk ? '1 : {17'h1ffff, 12'h000};
    act  = {busy, load_bias, feed_en, done, reset_sta, layer_done, feed_k, pos_row, pos_col};
    exp  = {cur.busy, cur.lb, cur.fe, cur.dn, cur.rs, cur.ld, KB'(cur.fk), NB'(cur.row), NB'(cur.col)};
    n_vec++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL cycle %0d outputs: got %h, expected %h", cyc_g, act & mask, exp & mask);
    end
    if (!stall) begin
      n_done += int'(done);
      n_rs   += int'(reset_sta);
      n_feed += int'(feed_en);
      n_ld   += int'(layer_done);
    end
    @(negedge clk);
  endtask

  task automatic clr_cnt();
    n_done = 0; n_rs = 0; n_feed = 0; n_ld = 0;
  endtask

  task automatic run_layer(input int od, input int k, output int cyc);
    out_dim = NB'(od); k_steps = KB'(k); start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!layer_done && cyc < 5000) begin
      tick();
      cyc++;
    end
    tick();
  endtask

  typedef struct {
    int od, k, tiles, cycles;
  } vec_t;

  vec_t tbl[8];
  int   cyc, t0, t1, i;

  initial begin
    cur = blank(0, 0, 0);
    dseen = 0;
    clr_cnt();

    // Layer cycles = tiles*(15+k)+1 counted from the start edge to FIN.
    tbl[0] = '{8, 4, 4, 77};
    tbl[1] = '{6, 2, 4, 69};
    tbl[2] = '{4, 0, 1, 16};
    tbl[3] = '{0, 3, 0, 1};
    tbl[4] = '{5, 1, 4, 65};
    tbl[5] = '{12, 3, 9, 163};
    tbl[6] = '{1, 1, 1, 17};
    tbl[7] = '{63, 0, 256, 3841};

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pos", 32'({pos_row, pos_col}), 0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[v]) begin
      clr_cnt();
      run_layer(tbl[v].od, tbl[v].k, cyc);
      chk($sformatf("tbl%0d_cycles", v), 32'(cyc), 32'(tbl[v].cycles));
      chk($sformatf("tbl%0d_done", v), 32'(n_done), 32'(tbl[v].tiles));
      chk($sformatf("tbl%0d_clear", v), 32'(n_rs), 32'(tbl[v].tiles));
      chk($sformatf("tbl%0d_feeds", v), 32'(n_feed), 32'(tbl[v].tiles * tbl[v].k));
      chk($sformatf("tbl%0d_ldone", v), 32'(n_ld), 1);
    end

    // DRAIN held by sta_idle=0 for 20 cycles after done
    sta_idle = 1'b0;
    out_dim = 6'd4; k_steps = 11'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 100 && !done; i++) tick();
    chk("drain_wait_done", 32'(done), 1);
    for (i = 0; i < 20; i++) tick();
    chk("drain_hold_rs", 32'(reset_sta), 0);
    chk("drain_hold_busy", 32'(busy), 1);
    sta_idle = 1'b1;
    tick();
    chk("drain_exit_rs", 32'(reset_sta), 1);
    tick();
    chk("drain_fin", 32'(layer_done), 1);
    tick();

    // Stall 5 cycles with feed_k=2
    out_dim = 6'd4; k_steps = 11'd6; start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 10 && !load_bias; i++) tick();
    t0 = cyc_g;
    for (i = 0; i < 20 && !(feed_en && feed_k == 11'd2); i++) tick();
    chk("stall_reach_k2", 32'(feed_k), 2);
    stall = 1'b1;
    for (i = 0; i < 5; i++) tick();
    chk("stall_hold_k", 32'(feed_k), 2);
    chk("stall_hold_fe", 32'(feed_en), 1);
    stall = 1'b0;
    for (i = 0; i < 50 && !done; i++) tick();
    t1 = cyc_g;
    chk("stall_latency", 32'(t1 - t0), 22);
    for (i = 0; i < 50 && !layer_done; i++) tick();
    chk("stall_fin", 32'(layer_done), 1);
    tick();

    // Async reset mid-FLUSH, then an empty layer
    out_dim = 6'd8; k_steps = 11'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 10 && !feed_en; i++) tick();
    for (i = 0; i < 10 && feed_en; i++) tick();
    tick(); tick(); tick();
    chk("pre_rst_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'({busy, load_bias, feed_en, done, reset_sta, layer_done, feed_k, pos_row, pos_col}), 0);
    tick();
    reset_n = 1'b1;
    tick();
    clr_cnt();
    run_layer(0, 5, cyc);
    chk("empty_cycles", 32'(cyc), 1);
    chk("empty_done", 32'(n_done), 0);
    chk("empty_ldone", 32'(n_ld), 1);

    // Randomized traffic against the model
    for (int r = 0; r < 4000; r++) begin
      start    = ($urandom % 10) == 0;
      stall    = ($urandom % 5) == 0;
      sta_idle = ($urandom % 3) != 0;
      out_dim  = NB'($urandom_range(0, 13));
      k_steps  = KB'($urandom_range(0, 5));
      tick();
    end
    start = 1'b0; stall = 1'b0; sta_idle = 1'b1;
    for (i = 0; i < 2000 && (busy || layer_done); i++) tick();
    chk("quiesce_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
